jk_reg_bank: RTL

- Parametrised successor to the single JK flip-flop: a WIDTH-bit bank of JK cells sharing one clock.
- Operates in four modes:
  - per-bit JK update
  - parallel load
  - synchronous binary up-count (JK cells in toggle chain)
  - synchronous binary down-count
- Registered terminal-count flag for cascading.
- Used as a general state/counter primitive in the sequential-logic exercises.

---
 rtl/jk_reg_bank_if.sv | 25 ++
 rtl/jk_reg_bank.sv | 109 ++++++++++
 2 files changed

// File: rtl/jk_reg_bank_if.sv
// Bus for jk_reg_bank: control, data inputs and registered bank state.
// JK_TOGGLE_CNT_EN adds the toggle_cnt output.
interface jk_reg_bank_if #(
  parameter int WIDTH = 8
);
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             tc;
`ifdef JK_TOGGLE_CNT_EN
  logic [CW-1:0]    toggle_cnt;

  modport master (output en, mode, j, k, d, input q, qbar, tc, toggle_cnt);
  modport slave  (input en, mode, j, k, d, output q, qbar, tc, toggle_cnt);
`else
  modport master (output en, mode, j, k, d, input q, qbar, tc);
  modport slave  (input en, mode, j, k, d, output q, qbar, tc);
`endif
endinterface

// File: rtl/jk_reg_bank.sv
// WIDTH-bit bank of JK cells: per-bit JK, parallel load, up/down count with
// registered wrap flag. JK_TOGGLE_CNT_EN adds a per-edge changed-bit count.
module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  jk_reg_bank_if.slave bus
);
  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_LOAD = 2'b01,
    MODE_UP   = 2'b10,
    MODE_DOWN = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic [WIDTH-1:0] next_q_s;
  logic             next_tc_s;
  logic [WIDTH-1:0] tog_up_s;
  logic [WIDTH-1:0] tog_dn_s;
  logic             carry_up_s;
  logic             borrow_dn_s;

  // Toggle chain: bit i flips when all lower bits are 1 (up) or 0 (down);
  // the final chain value is the wrap condition.
  always_comb begin
    carry_up_s  = 1'b1;
    borrow_dn_s = 1'b1;
    tog_up_s    = '0;
    tog_dn_s    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog_up_s[i] = carry_up_s;
      tog_dn_s[i] = borrow_dn_s;
      carry_up_s  = carry_up_s & q_r[i];
      borrow_dn_s = borrow_dn_s & ~q_r[i];
    end
  end

  // Next-state selection; en=0 holds and clears the flag.
  always_comb begin
    next_q_s  = q_r;
    next_tc_s = 1'b0;
    if (bus.en) begin
      case (mode_e'(bus.mode))
        MODE_JK:   next_q_s = (bus.j & ~q_r) | (~bus.k & q_r);
        MODE_LOAD: next_q_s = bus.d;
        MODE_UP: begin
          next_q_s  = q_r ^ tog_up_s;
          next_tc_s = carry_up_s;
        end
        MODE_DOWN: begin
          next_q_s  = q_r ^ tog_dn_s;
          next_tc_s = borrow_dn_s;
        end
        default: begin
          next_q_s  = q_r;
          next_tc_s = 1'b0;
        end
      endcase
    end else begin
      next_q_s  = q_r;
      next_tc_s = 1'b0;
    end
  end

  // Bank state and wrap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r  <= RESET_VAL;
      tc_r <= 1'b0;
    end else begin
      q_r  <= next_q_s;
      tc_r <= next_tc_s;
    end
  end

  assign bus.q    = q_r;
  assign bus.qbar = ~q_r;
  assign bus.tc   = tc_r;

`ifdef JK_TOGGLE_CNT_EN
  logic [CW-1:0] toggle_cnt_r;

  function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Number of bits that flip on this edge; hold and reset both give zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      toggle_cnt_r <= '0;
    end else begin
      toggle_cnt_r <= popcount(q_r ^ next_q_s);
    end
  end

  assign bus.toggle_cnt = toggle_cnt_r;
`endif
endmodule
